// File: rtl/uart_tx_fifo.sv
// Byte FIFO that feeds a UART transmitter through its send/busy handshake,
// so that bursty producers are decoupled from the serial line rate.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          ipClk,
    input  logic          rst,
    input  logic [7:0]    ipWrData,
    input  logic          ipWrEn,
    output logic          opFull,
    output logic          opEmpty,
    output logic [AW:0]   opCount,
    output logic          opOverflow,
    output logic [7:0]    opTxData,
    output logic          opTxSend,
    input  logic          ipTxBusy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          overflow_q;
    logic [7:0]    txData_q;
    logic          txSend_q;
    state_t        state_q;

    logic wrAccept;
    logic pop;

    // A write is judged against the registered full flag, so a pop in the
    // same cycle cannot make room for a write that arrived while full.
    always_comb begin
        wrAccept = ipWrEn && !full_q;
        pop      = (state_q == IDLE) && !empty_q && !ipTxBusy;
        wrPtr_d  = wrAccept ? wrPtr_q + AW'(1) : wrPtr_q;
        rdPtr_d  = pop ? rdPtr_q + AW'(1) : rdPtr_q;
        count_d  = count_q;
        case ({wrAccept, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == (AW+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge ipClk) begin
        if (wrAccept) begin
            mem[wrPtr_q] <= ipWrData;
        end
    end

    always_ff @(posedge ipClk) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= ipWrEn && full_q;
        end
    end

    // Send stays high until the UART acknowledges with busy, then the
    // sequencer waits for busy to fall before offering the next byte.
    always_ff @(posedge ipClk) begin
        if (rst) begin
            state_q  <= IDLE;
            txData_q <= 8'h00;
            txSend_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    txSend_q <= 1'b0;
                    if (pop) begin
                        txData_q <= mem[rdPtr_q];
                        txSend_q <= 1'b1;
                        state_q  <= SEND;
                    end
                end
                SEND: begin
                    if (ipTxBusy) begin
                        txSend_q <= 1'b0;
                        state_q  <= WAIT;
                    end
                end
                WAIT: begin
                    txSend_q <= 1'b0;
                    if (!ipTxBusy) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    txSend_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign opFull     = full_q;
    assign opEmpty    = empty_q;
    assign opCount    = count_q;
    assign opOverflow = overflow_q;
    assign opTxData   = txData_q;
    assign opTxSend   = txSend_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: written bytes are queued as expected
// transmissions and a monitor checks each send against the queue.
module tb_uart_tx_fifo;

    logic       ipClk;
    logic       rst;
    logic [7:0] ipWrData;
    logic       ipWrEn;
    logic       opFull;
    logic       opEmpty;
    logic [4:0] opCount;
    logic       opOverflow;
    logic [7:0] opTxData;
    logic       opTxSend;
    logic       ipTxBusy;

    int checks = 0;
    int failures = 0;
    int sendCount = 0;

    logic [7:0] expQ[$];

    logic manualMode = 1'b0;
    logic manualBusy = 1'b0;
    logic autoBusy = 1'b0;
    int   holdCycles = 20;
    int   holdCnt = 0;

    assign ipTxBusy = manualMode ? manualBusy : autoBusy;

    uart_tx_fifo #(.DEPTH(16)) dut (
        .ipClk(ipClk),
        .rst(rst),
        .ipWrData(ipWrData),
        .ipWrEn(ipWrEn),
        .opFull(opFull),
        .opEmpty(opEmpty),
        .opCount(opCount),
        .opOverflow(opOverflow),
        .opTxData(opTxData),
        .opTxSend(opTxSend),
        .ipTxBusy(ipTxBusy)
    );

    initial begin
        ipClk = 1'b0;
        forever #5 ipClk = ~ipClk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge ipClk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input bit accepted);
        ipWrData = data;
        ipWrEn   = 1'b1;
        if (accepted) expQ.push_back(data);
        tick();
        ipWrEn   = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (!(expQ.size() == 0 && !opTxSend && !ipTxBusy && opEmpty) && n < 3000) begin
            tick();
            n++;
        end
        checkOutput(name, 32'(n < 3000), 32'd1);
        tick();
    endtask

    // UART model: acknowledges a send with busy held for holdCycles clocks.
    initial begin
        forever begin
            @(posedge ipClk);
            #1;
            if (autoBusy) begin
                if (holdCnt <= 1) autoBusy = 1'b0;
                else holdCnt--;
            end else if (opTxSend && !manualMode) begin
                autoBusy = 1'b1;
                holdCnt  = holdCycles;
            end
        end
    end

    // Monitor: pops the scoreboard on every new send request.
    initial begin
        logic       prevSend;
        logic [7:0] held;
        int         overlap;
        prevSend = 1'b0;
        held     = 8'h00;
        overlap  = 0;
        forever begin
            @(negedge ipClk);
            if (opTxSend && !prevSend) begin
                sendCount++;
                held = opTxData;
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpectedSend actual=%0h expected=none", opTxData);
                end else begin
                    checkOutput("txData", 32'(opTxData), 32'(expQ.pop_front()));
                end
            end else if (opTxSend && prevSend) begin
                checkOutput("txDataStable", 32'(opTxData), 32'(held));
            end
            if (opTxSend && ipTxBusy) overlap++;
            if (!opTxSend && prevSend) begin
                checkOutput("sendDropLatency", 32'(overlap <= 1), 32'd1);
            end
            if (!opTxSend) overlap = 0;
            prevSend = opTxSend;
        end
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int n;
        int expCnt;
        int coinc;
        logic prevSend;

        rst      = 1'b1;
        ipWrEn   = 1'b0;
        ipWrData = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("resetEmpty", 32'(opEmpty), 32'd1);
        checkOutput("resetFull", 32'(opFull), 32'd0);
        checkOutput("resetCount", 32'(opCount), 32'd0);
        checkOutput("resetOverflow", 32'(opOverflow), 32'd0);
        checkOutput("resetSend", 32'(opTxSend), 32'd0);
        checkOutput("resetData", 32'(opTxData), 32'h00);

        // Single byte latency through an idle UART.
        manualMode = 1'b0;
        holdCycles = 20;
        for (int i = 0; i < 8; i++) tick();
        applyStimulus(8'hA5, 1'b1);
        checkOutput("t1EmptyAfterWrite", 32'(opEmpty), 32'd0);
        checkOutput("t1CountAfterWrite", 32'(opCount), 32'd1);
        checkOutput("t1SendNotYet", 32'(opTxSend), 32'd0);
        tick();
        checkOutput("t1Send", 32'(opTxSend), 32'd1);
        checkOutput("t1Data", 32'(opTxData), 32'hA5);
        checkOutput("t1EmptyAfterPop", 32'(opEmpty), 32'd1);
        checkOutput("t1CountAfterPop", 32'(opCount), 32'd0);
        tick();
        checkOutput("t1SendDropped", 32'(opTxSend), 32'd0);
        waitDrain("t1Drain");

        // Burst of five bytes drained in order.
        base = sendCount;
        for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b1);
        waitDrain("t2Drain");
        checkOutput("t2SendCount", 32'(sendCount - base), 32'd5);

        // Fill to full while the UART is busy, then overflow once.
        manualMode = 1'b1;
        manualBusy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'h10 + 8'(i), 1'b1);
            if (i == 14) checkOutput("t3NotFullAt15", 32'(opFull), 32'd0);
        end
        checkOutput("t3Full", 32'(opFull), 32'd1);
        checkOutput("t3Count16", 32'(opCount), 32'd16);
        applyStimulus(8'h20, 1'b0);
        checkOutput("t3OverflowPulse", 32'(opOverflow), 32'd1);
        checkOutput("t3CountHeld", 32'(opCount), 32'd16);
        tick();
        checkOutput("t3OverflowCleared", 32'(opOverflow), 32'd0);
        holdCycles = 3;
        manualMode = 1'b0;
        waitDrain("t3Drain");

        // Wrap-around with writes landing on pop cycles.
        manualMode = 1'b1;
        manualBusy = 1'b1;
        for (int i = 0; i < 12; i++) applyStimulus(8'h40 + 8'(i), 1'b1);
        base = sendCount;
        holdCycles = 2;
        manualMode = 1'b0;
        n = 0;
        while (sendCount < base + 8 && n < 500) begin
            tick();
            n++;
        end
        checkOutput("t4EightSent", 32'(sendCount - base), 32'd8);
        checkOutput("t4CountAfter8", 32'(opCount), 32'd4);
        expCnt = 4;
        coinc = 0;
        prevSend = opTxSend;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(8'h50 + 8'(i), 1'b1);
            if (opTxSend && !prevSend) begin
                coinc++;
            end else begin
                expCnt++;
            end
            checkOutput("t4CountWritePop", 32'(opCount), 32'(expCnt));
            prevSend = opTxSend;
        end
        checkOutput("t4CoincidentSeen", 32'(coinc > 0), 32'd1);
        waitDrain("t4Drain");
        checkOutput("t4TotalSends", 32'(sendCount - base), 32'd22);

        // Busy never rises: send and data hold.
        manualMode = 1'b1;
        manualBusy = 1'b0;
        applyStimulus(8'hC3, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("t5SendHeld", 32'(opTxSend), 32'd1);
            checkOutput("t5DataHeld", 32'(opTxData), 32'hC3);
            tick();
        end
        manualBusy = 1'b1;
        tick();
        checkOutput("t5SendDropped", 32'(opTxSend), 32'd0);
        manualBusy = 1'b0;
        waitDrain("t5Drain");

        // Reset while a byte is being offered.
        manualBusy = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(8'hE0 + 8'(i), 1'b1);
        manualBusy = 1'b0;
        tick();
        checkOutput("t6InSend", 32'(opTxSend), 32'd1);
        checkOutput("t6CountBefore", 32'(opCount), 32'd3);
        rst = 1'b1;
        manualBusy = 1'b1;
        tick();
        rst = 1'b0;
        expQ.delete();
        checkOutput("t6SendAfterRst", 32'(opTxSend), 32'd0);
        checkOutput("t6EmptyAfterRst", 32'(opEmpty), 32'd1);
        checkOutput("t6CountAfterRst", 32'(opCount), 32'd0);
        base = sendCount;
        for (int i = 0; i < 3; i++) tick();
        applyStimulus(8'h77, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("t6NoSendWhileBusy", 32'(sendCount - base), 32'd0);
        manualBusy = 1'b0;
        tick();
        checkOutput("t6NewSend", 32'(opTxSend), 32'd1);
        checkOutput("t6NewData", 32'(opTxData), 32'h77);
        manualBusy = 1'b1;
        tick();
        manualBusy = 1'b0;
        waitDrain("t6Drain");
        checkOutput("t6SendCount", 32'(sendCount - base), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
